// File: rtl/wen_align.sv
// Store-path byte-lane aligner: shifts the byte write-enable mask and store data up to address[1:0].
// Optional macro WEN_ALIGN_REG_EN registers the aligned outputs (1-cycle latency).
module wen_align (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  MEMWen_in,
    input  logic [31:0] address,
    input  logic [31:0] wdata_in,
    output logic [3:0]  MEMWen_out,
    output logic [31:0] wdata_out,
    output logic        misaligned,
    output logic        misalign_sticky
);

    logic [1:0]  off;
    logic [3:0]  wen_c;
    logic [31:0] wdata_c;
    logic        bad_c;
    logic        unused_addr;

    assign off         = address[1:0];
    assign unused_addr = ^address[31:2];
    assign wdata_c     = wdata_in << {off, 3'b000};

    always_comb begin
        wen_c = 4'h0;
        bad_c = 1'b0;
        case (MEMWen_in)
            4'h0: begin
                wen_c = 4'h0;
                bad_c = 1'b0;
            end
            4'h1: wen_c = 4'h1 << off;
            4'h3: begin
                // Halfwords may only start on an even byte.
                if (off[0]) bad_c = 1'b1;
                else        wen_c = 4'h3 << off;
            end
            4'hF: begin
                if (off != 2'd0) bad_c = 1'b1;
                else             wen_c = 4'hF;
            end
            default: bad_c = 1'b1;
        endcase
    end

`ifdef WEN_ALIGN_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            MEMWen_out <= 4'h0;
            wdata_out  <= 32'h0;
            misaligned <= 1'b0;
        end else begin
            MEMWen_out <= wen_c;
            wdata_out  <= wdata_c;
            misaligned <= bad_c;
        end
    end
`else
    assign MEMWen_out = wen_c;
    assign wdata_out  = wdata_c;
    assign misaligned = bad_c;
`endif

    // Sticky samples whatever misaligned drives, so it trails the registered flag when enabled.
    always_ff @(posedge clk) begin
        if (rst) misalign_sticky <= 1'b0;
        else     misalign_sticky <= misalign_sticky | misaligned;
    end

endmodule

// File: tb/tb_wen_align.sv
// Directed bench for wen_align: expected lane-aligned outputs are queued when driven and
// popped after the clock edge; misalign_sticky is tracked by a small reference model.
module tb_wen_align;

    logic        clk;
    logic        rst;
    logic [3:0]  MEMWen_in;
    logic [31:0] address;
    logic [31:0] wdata_in;
    logic [3:0]  MEMWen_out;
    logic [31:0] wdata_out;
    logic        misaligned;
    logic        misalign_sticky;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t prev_exp;
    logic prev_valid;
    logic exp_sticky;
    int   n_vec;
    int   n_fail;

    wen_align dut (
        .clk             (clk),
        .rst             (rst),
        .MEMWen_in       (MEMWen_in),
        .address         (address),
        .wdata_in        (wdata_in),
        .MEMWen_out      (MEMWen_out),
        .wdata_out       (wdata_out),
        .misaligned      (misaligned),
        .misalign_sticky (misalign_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        exp_t r;
        int   o;
        o      = int'(a[1:0]);
        r.data = 32'h0;
        r.wen  = 4'h0;
        r.mis  = 1'b0;
        for (int k = 0; k < 4; k++)
            if (k >= o) r.data[8*k +: 8] = d[8*(k-o) +: 8];
        case (w)
            4'h0: r.wen = 4'h0;
            4'h1: case (o)
                      0: r.wen = 4'h1;
                      1: r.wen = 4'h2;
                      2: r.wen = 4'h4;
                      default: r.wen = 4'h8;
                  endcase
            4'h3: begin
                if (o == 0)      r.wen = 4'h3;
                else if (o == 2) r.wen = 4'hC;
                else             r.mis = 1'b1;
            end
            4'hF: begin
                if (o == 0) r.wen = 4'hF;
                else        r.mis = 1'b1;
            end
            default: r.mis = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        n_vec++;
        assert (MEMWen_out === e.wen) else begin
            n_fail++;
            $error("FAIL %s MEMWen_out observed=%h expected=%h", tag, MEMWen_out, e.wen);
        end
        n_vec++;
        assert (wdata_out === e.data) else begin
            n_fail++;
            $error("FAIL %s wdata_out observed=%h expected=%h", tag, wdata_out, e.data);
        end
        n_vec++;
        assert (misaligned === e.mis) else begin
            n_fail++;
            $error("FAIL %s misaligned observed=%b expected=%b", tag, misaligned, e.mis);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        exp_t got;
        logic mis_edge;
        @(negedge clk);
        rst       = r;
        MEMWen_in = w;
        address   = a;
        wdata_in  = d;
        e = model(w, a, d);
`ifdef WEN_ALIGN_REG_EN
        // Registered outputs still show the previous vector until the next edge.
        #1;
        if (prev_valid) check_out({tag, "_lag"}, prev_exp);
        mis_edge = prev_exp.mis;
        if (r) sb.push_back('0);
        else   sb.push_back(e);
`else
        mis_edge = e.mis;
        sb.push_back(e);
`endif
        @(posedge clk);
        exp_sticky = r ? 1'b0 : (exp_sticky | mis_edge);
        prev_exp   = r ? '0 : e;
        prev_valid = 1'b1;
        #1;
        got = sb.pop_front();
        check_out(tag, got);
        n_vec++;
        assert (misalign_sticky === exp_sticky) else begin
            n_fail++;
            $error("FAIL %s misalign_sticky observed=%b expected=%b", tag, misalign_sticky, exp_sticky);
        end
    endtask

    initial begin
        logic [3:0] wsel [5];
        n_vec      = 0;
        n_fail     = 0;
        exp_sticky = 1'b0;
        prev_exp   = '0;
        prev_valid = 1'b0;
        rst        = 1'b1;
        MEMWen_in  = 4'h0;
        address    = 32'h0;
        wdata_in   = 32'h0;
        wsel[0] = 4'h0; wsel[1] = 4'h1; wsel[2] = 4'h3; wsel[3] = 4'hF; wsel[4] = 4'h6;

        step("rst0", 1'b1, 4'h0, 32'h0, 32'h0);
        step("rst1", 1'b1, 4'h0, 32'h0, 32'h0);
        step("idle", 1'b0, 4'h0, 32'h0, 32'h0);

        step("o0_sb", 1'b0, 4'h1, 32'h1223_4570, 32'hDEAD_BEEF);
        step("o0_sh", 1'b0, 4'h3, 32'h1223_4570, 32'h1234_5678);
        step("o0_sw", 1'b0, 4'hF, 32'h1223_4570, 32'hCAFE_F00D);

        step("o1_sb", 1'b0, 4'h1, 32'h1223_4571, 32'h0000_00A5);
        step("o1_sh", 1'b0, 4'h3, 32'h1223_4571, 32'h0000_ABCD);
        step("o1_sw", 1'b0, 4'hF, 32'h1223_4571, 32'h8765_4321);
        step("o1_hold", 1'b0, 4'h1, 32'h1223_4570, 32'h0000_0011);

        step("o2_sb", 1'b0, 4'h1, 32'h1223_4572, 32'h0000_005A);
        step("o2_sh", 1'b0, 4'h3, 32'h1223_4572, 32'h0000_ABCD);
        step("o2_sw", 1'b0, 4'hF, 32'h1223_4572, 32'h0000_ABCD);

        step("o3_sb", 1'b0, 4'h1, 32'h1223_4573, 32'h0000_00C3);
        step("o3_sh", 1'b0, 4'h3, 32'h1223_4573, 32'hFFFF_FFFF);
        step("o3_sw", 1'b0, 4'hF, 32'h1223_4573, 32'h1357_9BDF);
        step("o3_none", 1'b0, 4'h0, 32'h1223_4573, 32'hAABB_CCDD);
        step("ill5", 1'b0, 4'h5, 32'h1223_4570, 32'h0102_0304);

        step("mid_rst", 1'b1, 4'hF, 32'h0000_0001, 32'h0BAD_0BAD);
        step("post_rst", 1'b0, 4'h3, 32'hFFFF_FFFE, 32'h0000_BEEF);
        step("re_err", 1'b0, 4'h3, 32'h0000_0003, 32'h0000_BEEF);
        step("re_hold", 1'b0, 4'h0, 32'h0000_0000, 32'h0);

        for (int i = 0; i < 12; i++)
            step("rand", 1'b0, wsel[$urandom_range(0, 4)], $urandom, $urandom);

        step("flush", 1'b0, 4'h0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
